// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY wait cycles, RV32I load/store sizing.
// Optional macro DMEM_RESP_MISALIGN_EN flags misaligned half/word accesses as errors.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic        commit_s;
    logic        accept_s;

    logic        cap_we_r;
    logic [31:0] cap_addr_r;
    logic [31:0] cap_wdata_r;
    logic [2:0]  cap_funct3_r;

    logic        req_ready_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;

    logic [31:0] mem_r [DEPTH_WORDS];

    logic        eff_we_s;
    logic [31:0] eff_addr_s;
    logic [31:0] eff_wdata_s;
    logic [2:0]  eff_funct3_s;
    logic [AW-1:0] idx_s;
    logic [31:0] rd_word_s;
    logic        legal_s;
    logic        misalign_s;
    logic        err_s;
    logic        wr_en_s;
    logic [31:0] load_data_s;
    logic        unused_s;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  funct3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  lane);
        logic [31:0] m;
        m = word;
        case (funct3[1:0])
            2'b00: begin
                case (lane)
                    2'd0:    m[7:0]   = wdata[7:0];
                    2'd1:    m[15:8]  = wdata[7:0];
                    2'd2:    m[23:16] = wdata[7:0];
                    2'd3:    m[31:24] = wdata[7:0];
                    default: m = word;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    m[31:16] = wdata[15:0];
                end else begin
                    m[15:0] = wdata[15:0];
                end
            end
            2'b10:   m = wdata;
            default: m = word;
        endcase
        return m;
    endfunction

    assign accept_s = req_valid && req_ready_r;

    // With LATENCY=0 the commit edge is the accept edge, so the live request is used there.
    always_comb begin
        if (state_r == IDLE) begin
            eff_we_s     = req_we;
            eff_addr_s   = req_addr;
            eff_wdata_s  = req_wdata;
            eff_funct3_s = req_funct3;
        end else begin
            eff_we_s     = cap_we_r;
            eff_addr_s   = cap_addr_r;
            eff_wdata_s  = cap_wdata_r;
            eff_funct3_s = cap_funct3_r;
        end
    end

    assign idx_s     = eff_addr_s[AW+1:2];
    assign rd_word_s = mem_r[idx_s];
    assign unused_s  = ^eff_addr_s[31:AW+2];

    // Decode legality, alignment and the load result for the current effective request.
    always_comb begin
        legal_s = 1'b0;
        case ({eff_we_s, eff_funct3_s})
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
            4'b1000, 4'b1001, 4'b1010: legal_s = 1'b1;
            default:                   legal_s = 1'b0;
        endcase
`ifdef DMEM_RESP_MISALIGN_EN
        misalign_s = ((eff_funct3_s[1:0] == 2'b01) && eff_addr_s[0]) ||
                     ((eff_funct3_s[1:0] == 2'b10) && (eff_addr_s[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        err_s   = !legal_s || misalign_s;
        wr_en_s = commit_s && eff_we_s && !err_s && !rst;
        if (err_s || eff_we_s) begin
            load_data_s = 32'd0;
        end else begin
            load_data_s = load_extract(rd_word_s, eff_funct3_s, eff_addr_s[1:0]);
        end
    end

    // Next-state logic; commit_s marks the edge that writes memory and samples read data.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        commit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_nx_s = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_nx_s = RESP;
                        commit_s   = 1'b1;
                    end else begin
                        state_nx_s = WAIT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_nx_s = RESP;
                    cnt_nx_s   = 4'd0;
                    commit_s   = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // State, captured request and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'd0;
            rsp_err_r    <= 1'b0;
            cap_we_r     <= 1'b0;
            cap_addr_r   <= 32'd0;
            cap_wdata_r  <= 32'd0;
            cap_funct3_r <= 3'd0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            req_ready_r <= (state_nx_s == IDLE);
            rsp_valid_r <= (state_nx_s == RESP);
            if (accept_s) begin
                cap_we_r     <= req_we;
                cap_addr_r   <= req_addr;
                cap_wdata_r  <= req_wdata;
                cap_funct3_r <= req_funct3;
            end
            if (commit_s) begin
                rsp_rdata_r <= load_data_s;
                rsp_err_r   <= err_s;
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_rdata_r <= 32'd0;
                rsp_err_r   <= 1'b0;
            end
        end
    end

    // Storage array is never cleared; only legal stores on the commit edge write it.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= store_merge(rd_word_s, eff_wdata_s, eff_funct3_s, eff_addr_s[1:0]);
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, count cycles to rsp_valid, check response, handshake.
    task automatic run(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'd3);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, req_ready, rsp_valid}, 32'd2);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);

        run("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0);
        run("lw10", 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);

        run("sw20", 1'b1, 32'h20, 32'h000080FF, 3'b010, 32'd0, 1'b0);
        run("lb20", 1'b0, 32'h20, 32'd0, 3'b000, 32'hFFFFFFFF, 1'b0);
        run("lbu20", 1'b0, 32'h20, 32'd0, 3'b100, 32'h000000FF, 1'b0);
        run("lh20", 1'b0, 32'h20, 32'd0, 3'b001, 32'hFFFF80FF, 1'b0);
        run("lhu20", 1'b0, 32'h20, 32'd0, 3'b101, 32'h000080FF, 1'b0);

        run("sw30", 1'b1, 32'h30, 32'h00000000, 3'b010, 32'd0, 1'b0);
        run("sb31", 1'b1, 32'h31, 32'hFFFFFFAB, 3'b000, 32'd0, 1'b0);
        run("lw30", 1'b0, 32'h30, 32'd0, 3'b010, 32'h0000AB00, 1'b0);
        run("lw1030", 1'b0, 32'h1030, 32'd0, 3'b010, 32'h0000AB00, 1'b0);
        run("lb31", 1'b0, 32'h31, 32'd0, 3'b000, 32'hFFFFFFAB, 1'b0);
        run("sh1032", 1'b1, 32'h1032, 32'hFFFF1234, 3'b001, 32'd0, 1'b0);
        run("lw30b", 1'b0, 32'h30, 32'd0, 3'b010, 32'h1234AB00, 1'b0);
        run("lhu32", 1'b0, 32'h32, 32'd0, 3'b101, 32'h00001234, 1'b0);

        // Backpressure: response held for 5 cycles with rsp_ready low.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = 3'b010;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_wait", n, 32'd2);
        req_valid = 1'b1;
        req_addr  = 32'h20;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_idle", {30'd0, req_ready, rsp_valid}, 32'd2);

        run("st011", 1'b1, 32'h10, 32'h55555555, 3'b011, 32'd0, 1'b1);
        run("sbu_ill", 1'b1, 32'h10, 32'h55555555, 3'b100, 32'd0, 1'b1);
        run("ld110", 1'b0, 32'h10, 32'd0, 3'b110, 32'd0, 1'b1);
        run("lw10_keep", 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);
`ifdef DMEM_RESP_MISALIGN_EN
        run("lw12", 1'b0, 32'h12, 32'd0, 3'b010, 32'd0, 1'b1);
`else
        run("lw12", 1'b0, 32'h12, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);
`endif

        // Reset during WAIT aborts the store.
        run("sw40", 1'b1, 32'h40, 32'hCAFEF00D, 3'b010, 32'd0, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h40;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        tick();
        req_valid = 1'b0;
        chk("wait_req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
        chk("abort_rdata", rsp_rdata, 32'd0);
        tick();
        tick();
        run("lw40", 1'b0, 32'h40, 32'd0, 3'b010, 32'hCAFEF00D, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
